lsm_pipelined: RTL and testbench
================================

LSM_PIPELINED -- requirements
Module: lsm_pipelined

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: max in-flight entries (memory or bypass); power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: cycles without ack before bus abort; 0 disables timeout.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 input_valid_i in 1 / input_ready_o out 1: request handshake; transfer when both high on a clock edge.
REQ-006 addr_i in 32, enable_i in 1 (1=memory access, 0=bypass), write_i in 1 (1=store), store_data_i in 32 (store data; bypass result when enable_i=0), sel_i in 4 (byte lanes), unsigned_i in 1 (load zero-extend).
REQ-007 reg_write_i in 1, reg_addr_i in 5: writeback tag carried with the request.
REQ-008 Wishbone B4 pipelined master: wb_adr_o out 32, wb_dat_i in 32, wb_dat_o out 32, wb_we_o out 1, wb_sel_o out 4, wb_stb_o out 1, wb_ack_i in 1, wb_cyc_o out 1, wb_stall_i in 1.
REQ-009 output_valid_o out 1, reg_write_o out 1, reg_addr_o out 5, reg_data_o out 32: in-order writeback, one-cycle pulse per entry.
REQ-010 timeout_o out 1: one-cycle pulse on bus abort.

Function
REQ-011 Tag FIFO (depth MAX_OUTSTANDING) holds per accepted request: enable, write, reg_write, reg_addr, sel, unsigned, bypass data.
REQ-012 input_ready_o = (FIFO count < MAX_OUTSTANDING) and not (wb_stb_o and wb_stall_i); combinational.
REQ-013 Accepted request with enable_i=1: next cycle wb_stb_o=1 with adr/dat/we/sel registered from inputs; held stable while wb_stall_i=1; stb drops after the cycle where stall=0 unless a new request is accepted that cycle (back-to-back stb allowed).
REQ-014 wb_cyc_o = 1 whenever wb_stb_o=1 or any memory entry is awaiting ack; 0 otherwise.
REQ-015 Every accepted request pushes one FIFO entry; order of writeback equals order of acceptance.
REQ-016 Head memory entry pops on wb_ack_i=1; head bypass entry pops in the cycle it is head without ack; one pop per cycle max.
REQ-017 Push and pop in the same cycle leave count unchanged; acceptance when full is impossible (ready low).
REQ-018 wb_ack_i with no memory entry outstanding is ignored.
REQ-019 Writeback registered: popped entry appears on outputs the cycle after the pop with output_valid_o=1.
REQ-020 reg_write_o = tag reg_write AND NOT tag write; reg_addr_o = tag reg_addr.
REQ-021 Load data: sel 0001/0010/0100/1000 selects byte 0/1/2/3; 0011/1100 selects half 0/1; 1111 full word; other sel returns wb_dat_i unchanged; sign-extend unless unsigned=1.
REQ-022 Store writeback: reg_data_o=0; bypass writeback: reg_data_o = stored bypass data.
REQ-023 Timeout counter clears on ack or when no memory entry is outstanding, else increments; on reaching TIMEOUT_CYCLES: cyc/stb drop next cycle, FIFO flushed, timeout_o pulses, no output_valid_o for flushed entries.
REQ-024 Acks arriving after an abort and before the next request are ignored.

Reset
REQ-025 While rst_i=1: wb_cyc_o, wb_stb_o, wb_we_o, output_valid_o, reg_write_o, timeout_o = 0; wb_adr_o, wb_dat_o, reg_data_o = 0; wb_sel_o=0; reg_addr_o=0; FIFO empty; timeout counter 0.
REQ-026 Reset asserted mid-transaction drops cyc/stb immediately (asynchronous); pending entries discarded without writeback.
REQ-027 input_ready_o = 1 in the first cycle after rst_i deasserts.

Verification
REQ-028 Single load addr 0x100, sel 0001, unsigned 0, reg_addr 5, ack 1 cycle later with dat 0x000000F0 -> output_valid_o=1, reg_write_o=1, reg_addr_o=5, reg_data_o=0xFFFFFFF0.
REQ-029 Four back-to-back loads, stall=0, acks delayed 3 cycles, dat 0x11,0x22,0x33,0x44 -> 4 stb cycles contiguous, fifth request sees ready=0, writebacks in order 0x11..0x44.
REQ-030 Store 0xDEADBEEF to 0x200, sel 1111, stall held 2 cycles -> stb/adr/dat stable 3 cycles, writeback reg_write_o=0, reg_data_o=0.
REQ-031 Load (ack delayed 5) then bypass with store_data 0x1234, reg_addr 7 -> bypass writeback strictly after load writeback, reg_data_o=0x1234.
REQ-032 Load, no ack for TIMEOUT_CYCLES=8 -> cyc drops, timeout_o one pulse, no output_valid_o; late ack ignored.
REQ-033 rst_i asserted while 2 loads outstanding -> cyc/stb 0 immediately, no writeback, ready=1 after release.

Source files
------------

// File: rtl/lsm_pipelined.sv
// rtl/lsm_pipelined.sv - pipelined load/store unit with Wishbone B4 pipelined master
// In-order writeback through a tag FIFO; ack data is queued so bypass entries cannot lose an ack.
module lsm_pipelined #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        input_valid_i,
   output logic        input_ready_o,
   input  logic [31:0] addr_i,
   input  logic        enable_i,
   input  logic        write_i,
   input  logic [31:0] store_data_i,
   input  logic [3:0]  sel_i,
   input  logic        unsigned_i,
   input  logic        reg_write_i,
   input  logic [4:0]  reg_addr_i,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        wb_cyc_o,
   input  logic        wb_stall_i,
   output logic        output_valid_o,
   output logic        reg_write_o,
   output logic [4:0]  reg_addr_o,
   output logic [31:0] reg_data_o,
   output logic        timeout_o
);
   localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CW-1:0] DEPTH  = CW'(MAX_OUTSTANDING);

   logic          t_en   [MAX_OUTSTANDING];
   logic          t_wr   [MAX_OUTSTANDING];
   logic          t_rw   [MAX_OUTSTANDING];
   logic [4:0]    t_ra   [MAX_OUTSTANDING];
   logic [3:0]    t_sel  [MAX_OUTSTANDING];
   logic          t_uns  [MAX_OUTSTANDING];
   logic [31:0]   t_byp  [MAX_OUTSTANDING];
   logic [31:0]   d_mem  [MAX_OUTSTANDING];

   logic [AW-1:0] wr_ptr, rd_ptr, d_wr_ptr, d_rd_ptr;
   logic [CW-1:0] count, mem_count, d_count;
   logic [TW-1:0] tcnt;

   logic          accept, push_mem, awaiting, ack_v, head_valid;
   logic          pop, pop_mem, d_take, d_put, abort;
   logic [31:0]   ld_raw;

   function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [3:0] s,
                                            input logic u);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = d[7:0];
      h = d[15:0];
      r = d;
      case (s)
         4'b0001: b = d[7:0];
         4'b0010: b = d[15:8];
         4'b0100: b = d[23:16];
         4'b1000: b = d[31:24];
         4'b1100: h = d[31:16];
         default: ;
      endcase
      case (s)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: r = u ? {24'b0, b} : {{24{b[7]}}, b};
         4'b0011, 4'b1100:                   r = u ? {16'b0, h} : {{16{h[15]}}, h};
         default:                            r = d;
      endcase
      return r;
   endfunction

   assign input_ready_o = (count < DEPTH) && !(wb_stb_o && wb_stall_i);
   assign accept        = input_valid_i && input_ready_o;
   assign push_mem      = accept && enable_i;
   // Memory entries not yet matched by an ack; acks beyond these are stray.
   assign awaiting      = mem_count > d_count;
   assign ack_v         = wb_ack_i && awaiting;
   assign wb_cyc_o      = wb_stb_o || awaiting;
   assign head_valid    = count != '0;
   assign pop           = head_valid && (!t_en[rd_ptr] || d_count != '0 || ack_v);
   assign pop_mem       = pop && t_en[rd_ptr];
   assign d_take        = pop_mem && d_count != '0;
   assign d_put         = ack_v && !(pop_mem && d_count == '0);
   assign ld_raw        = (d_count != '0) ? d_mem[d_rd_ptr] : wb_dat_i;
   assign abort         = (TIMEOUT_CYCLES != 0) && awaiting && !ack_v && tcnt == T_LAST;

   always_ff @(posedge clk_i) begin
      if (accept) begin
         t_en[wr_ptr]  <= enable_i;
         t_wr[wr_ptr]  <= write_i;
         t_rw[wr_ptr]  <= reg_write_i;
         t_ra[wr_ptr]  <= reg_addr_i;
         t_sel[wr_ptr] <= sel_i;
         t_uns[wr_ptr] <= unsigned_i;
         t_byp[wr_ptr] <= store_data_i;
      end
      if (d_put)
         d_mem[d_wr_ptr] <= wb_dat_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_stb_o       <= 1'b0;
         wb_we_o        <= 1'b0;
         wb_adr_o       <= '0;
         wb_dat_o       <= '0;
         wb_sel_o       <= '0;
         output_valid_o <= 1'b0;
         reg_write_o    <= 1'b0;
         reg_addr_o     <= '0;
         reg_data_o     <= '0;
         timeout_o      <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         d_wr_ptr       <= '0;
         d_rd_ptr       <= '0;
         count          <= '0;
         mem_count      <= '0;
         d_count        <= '0;
         tcnt           <= '0;
      end else begin
         output_valid_o <= 1'b0;
         reg_write_o    <= 1'b0;
         timeout_o      <= 1'b0;
         if (abort) begin
            // Abort also discards anything accepted on this edge.
            wb_stb_o  <= 1'b0;
            timeout_o <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            d_wr_ptr  <= '0;
            d_rd_ptr  <= '0;
            count     <= '0;
            mem_count <= '0;
            d_count   <= '0;
            tcnt      <= '0;
         end else begin
            if (push_mem) begin
               wb_stb_o <= 1'b1;
               wb_adr_o <= addr_i;
               wb_dat_o <= store_data_i;
               wb_we_o  <= write_i;
               wb_sel_o <= sel_i;
            end else if (!wb_stall_i) begin
               wb_stb_o <= 1'b0;
            end

            count     <= count + CW'(accept) - CW'(pop);
            mem_count <= mem_count + CW'(push_mem) - CW'(pop_mem);
            d_count   <= d_count + CW'(d_put) - CW'(d_take);
            if (accept) wr_ptr   <= wr_ptr + AW'(1);
            if (pop)    rd_ptr   <= rd_ptr + AW'(1);
            if (d_put)  d_wr_ptr <= d_wr_ptr + AW'(1);
            if (d_take) d_rd_ptr <= d_rd_ptr + AW'(1);

            if (ack_v || !awaiting)
               tcnt <= '0;
            else
               tcnt <= tcnt + TW'(1);

            if (pop) begin
               output_valid_o <= 1'b1;
               reg_write_o    <= t_rw[rd_ptr] && !t_wr[rd_ptr];
               reg_addr_o     <= t_ra[rd_ptr];
               if (!t_en[rd_ptr])
                  reg_data_o <= t_byp[rd_ptr];
               else if (t_wr[rd_ptr])
                  reg_data_o <= '0;
               else
                  reg_data_o <= load_ext(ld_raw, t_sel[rd_ptr], t_uns[rd_ptr]);
            end
         end
      end
   end
endmodule

// File: tb/tb_lsm_pipelined.sv
// tb/tb_lsm_pipelined.sv - directed self-checking bench for lsm_pipelined
module tb_lsm_pipelined;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        input_valid = 1'b0;
   logic        input_ready;
   logic [31:0] addr = '0;
   logic        enable = 1'b0;
   logic        write = 1'b0;
   logic [31:0] store_data = '0;
   logic [3:0]  sel = '0;
   logic        uns = 1'b0;
   logic        reg_write = 1'b0;
   logic [4:0]  reg_addr = '0;
   logic [31:0] wb_adr, wb_dat_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_we, wb_stb, wb_cyc;
   logic [3:0]  wb_sel;
   logic        wb_ack = 1'b0;
   logic        wb_stall = 1'b0;
   logic        output_valid, reg_write_q, timeout;
   logic [4:0]  reg_addr_q;
   logic [31:0] reg_data_q;

   int errors = 0;
   int checks = 0;

   lsm_pipelined #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .input_valid_i(input_valid), .input_ready_o(input_ready),
      .addr_i(addr), .enable_i(enable), .write_i(write), .store_data_i(store_data),
      .sel_i(sel), .unsigned_i(uns), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
      .wb_adr_o(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we),
      .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_cyc_o(wb_cyc),
      .wb_stall_i(wb_stall),
      .output_valid_o(output_valid), .reg_write_o(reg_write_q), .reg_addr_o(reg_addr_q),
      .reg_data_o(reg_data_q), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic en, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic u,
                      input logic [4:0] ra);
      input_valid = 1'b1;
      enable      = en;
      write       = wr;
      addr        = a;
      store_data  = d;
      sel         = s;
      uns         = u;
      reg_write   = 1'b1;
      reg_addr    = ra;
   endtask

   initial begin
      // reset state
      @(negedge clk);
      check("rst_cyc", 32'(wb_cyc), 32'h0);
      check("rst_stb", 32'(wb_stb), 32'h0);
      check("rst_adr", wb_adr, 32'h0);
      check("rst_sel", 32'(wb_sel), 32'h0);
      check("rst_valid", 32'(output_valid), 32'h0);
      check("rst_data", reg_data_q, 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(input_ready), 32'h1);

      // single signed byte load
      cyc();
      req(1'b1, 1'b0, 32'h100, 32'h0, 4'b0001, 1'b0, 5'd5);
      @(negedge clk);
      check("ld1_ready", 32'(input_ready), 32'h1);
      cyc();
      input_valid = 1'b0;
      @(negedge clk);
      check("ld1_stb", 32'(wb_stb), 32'h1);
      check("ld1_adr", wb_adr, 32'h100);
      check("ld1_we", 32'(wb_we), 32'h0);
      check("ld1_sel", 32'(wb_sel), 32'h1);
      cyc();
      check("ld1_stb_drop", 32'(wb_stb), 32'h0);
      check("ld1_cyc_wait", 32'(wb_cyc), 32'h1);
      wb_ack = 1'b1;
      wb_dat_i = 32'h000000F0;
      cyc();
      wb_ack = 1'b0;
      @(negedge clk);
      check("ld1_valid", 32'(output_valid), 32'h1);
      check("ld1_regw", 32'(reg_write_q), 32'h1);
      check("ld1_raddr", 32'(reg_addr_q), 32'h5);
      check("ld1_data", reg_data_q, 32'hFFFFFFF0);
      check("ld1_cyc_idle", 32'(wb_cyc), 32'h0);
      cyc();
      check("ld1_valid_pulse", 32'(output_valid), 32'h0);

      // four back-to-back loads, acks three cycles after each stb
      cyc();
      req(1'b1, 1'b0, 32'h300, 32'h0, 4'b1111, 1'b0, 5'd10);
      cyc();
      check("b2b_stb0", 32'(wb_stb), 32'h1);
      req(1'b1, 1'b0, 32'h304, 32'h0, 4'b1111, 1'b0, 5'd11);
      cyc();
      check("b2b_stb1", 32'(wb_stb), 32'h1);
      check("b2b_adr1", wb_adr, 32'h304);
      req(1'b1, 1'b0, 32'h308, 32'h0, 4'b1111, 1'b0, 5'd12);
      cyc();
      check("b2b_stb2", 32'(wb_stb), 32'h1);
      req(1'b1, 1'b0, 32'h30C, 32'h0, 4'b1111, 1'b0, 5'd13);
      cyc();
      check("b2b_stb3", 32'(wb_stb), 32'h1);
      check("b2b_adr3", wb_adr, 32'h30C);
      req(1'b1, 1'b0, 32'h310, 32'h0, 4'b1111, 1'b0, 5'd14);
      wb_ack = 1'b1;
      wb_dat_i = 32'h11;
      @(negedge clk);
      check("b2b_full_ready", 32'(input_ready), 32'h0);
      cyc();
      input_valid = 1'b0;
      wb_dat_i = 32'h22;
      check("b2b_stb_end", 32'(wb_stb), 32'h0);
      check("b2b_wb0", reg_data_q, 32'h11);
      check("b2b_v0", 32'(output_valid), 32'h1);
      cyc();
      wb_dat_i = 32'h33;
      check("b2b_wb1", reg_data_q, 32'h22);
      check("b2b_ra1", 32'(reg_addr_q), 32'd11);
      cyc();
      wb_dat_i = 32'h44;
      check("b2b_wb2", reg_data_q, 32'h33);
      cyc();
      wb_ack = 1'b0;
      check("b2b_wb3", reg_data_q, 32'h44);
      check("b2b_v3", 32'(output_valid), 32'h1);
      check("b2b_ra3", 32'(reg_addr_q), 32'd13);
      cyc();
      check("b2b_done", 32'(output_valid), 32'h0);

      // store with two stall cycles
      req(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b1111, 1'b0, 5'd3);
      cyc();
      input_valid = 1'b0;
      wb_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) wb_stall = 1'b0;
         @(negedge clk);
         check("st_stb", 32'(wb_stb), 32'h1);
         check("st_adr", wb_adr, 32'h200);
         check("st_dat", wb_dat_o, 32'hDEADBEEF);
         check("st_we", 32'(wb_we), 32'h1);
         check("st_ready", 32'(input_ready), (k == 2) ? 32'h1 : 32'h0);
         cyc();
      end
      check("st_stb_drop", 32'(wb_stb), 32'h0);
      wb_ack = 1'b1;
      cyc();
      wb_ack = 1'b0;
      check("st_valid", 32'(output_valid), 32'h1);
      check("st_regw", 32'(reg_write_q), 32'h0);
      check("st_data", reg_data_q, 32'h0);

      // load with slow ack followed by bypass
      cyc();
      req(1'b1, 1'b0, 32'h400, 32'h0, 4'b0011, 1'b1, 5'd6);
      cyc();
      req(1'b0, 1'b0, 32'h0, 32'h1234, 4'b0000, 1'b0, 5'd7);
      @(negedge clk);
      check("byp_ready", 32'(input_ready), 32'h1);
      cyc();
      input_valid = 1'b0;
      check("byp_no_stb", 32'(wb_stb), 32'h0);
      for (int k = 2; k <= 6; k++) begin
         if (k == 6) begin
            wb_ack = 1'b1;
            wb_dat_i = 32'hABCD8765;
         end
         @(negedge clk);
         check("byp_wait", 32'(output_valid), 32'h0);
         cyc();
      end
      wb_ack = 1'b0;
      check("byp_ld_valid", 32'(output_valid), 32'h1);
      check("byp_ld_data", reg_data_q, 32'h00008765);
      check("byp_ld_ra", 32'(reg_addr_q), 32'd6);
      cyc();
      check("byp_valid", 32'(output_valid), 32'h1);
      check("byp_data", reg_data_q, 32'h1234);
      check("byp_ra", 32'(reg_addr_q), 32'd7);
      check("byp_regw", 32'(reg_write_q), 32'h1);
      cyc();
      check("byp_done", 32'(output_valid), 32'h0);

      // bus timeout and late ack
      req(1'b1, 1'b0, 32'h500, 32'h0, 4'b1111, 1'b0, 5'd9);
      cyc();
      input_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         wb_ack = (k == 10);
         @(negedge clk);
         check("to_cyc", 32'(wb_cyc), (k <= 8) ? 32'h1 : 32'h0);
         check("to_pulse", 32'(timeout), (k == 9) ? 32'h1 : 32'h0);
         check("to_no_valid", 32'(output_valid), 32'h0);
         cyc();
      end
      wb_ack = 1'b0;
      check("to_ready", 32'(input_ready), 32'h1);

      // reset while two loads outstanding
      req(1'b1, 1'b0, 32'h600, 32'h0, 4'b1111, 1'b0, 5'd1);
      cyc();
      req(1'b1, 1'b0, 32'h604, 32'h0, 4'b1111, 1'b0, 5'd2);
      cyc();
      input_valid = 1'b0;
      @(negedge clk);
      check("rs_stb_before", 32'(wb_stb), 32'h1);
      rst = 1'b1;
      #1;
      check("rs_stb_async", 32'(wb_stb), 32'h0);
      check("rs_cyc_async", 32'(wb_cyc), 32'h0);
      cyc();
      rst = 1'b0;
      wb_ack = 1'b1;
      @(negedge clk);
      check("rs_ready", 32'(input_ready), 32'h1);
      check("rs_cyc_idle", 32'(wb_cyc), 32'h0);
      cyc();
      wb_ack = 1'b0;
      check("rs_no_valid", 32'(output_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
